// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state, opcode and datapath select encodings for the multi-cycle sequencer
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] ALU_B_RT      = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct to one-hot instruction class flags
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic       o_rtype,
  output logic       o_jr,
  output logic       o_lw,
  output logic       o_sw,
  output logic       o_addi,
  output logic       o_beq,
  output logic       o_bne,
  output logic       o_j,
  output logic       o_jal,
  output logic       o_illegal
);

  always_comb begin
    o_rtype   = 1'b0;
    o_jr      = 1'b0;
    o_lw      = 1'b0;
    o_sw      = 1'b0;
    o_addi    = 1'b0;
    o_beq     = 1'b0;
    o_bne     = 1'b0;
    o_j       = 1'b0;
    o_jal     = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      // JR shares the R-type opcode; keep the flags mutually exclusive
      OP_RTYPE: begin
        if (i_funct == FN_JR) o_jr = 1'b1;
        else                  o_rtype = 1'b1;
      end
      OP_LW:   o_lw   = 1'b1;
      OP_SW:   o_sw   = 1'b1;
      OP_ADDI: o_addi = 1'b1;
      OP_BEQ:  o_beq  = 1'b1;
      OP_BNE:  o_bne  = 1'b1;
      OP_J:    o_j    = 1'b1;
      OP_JAL:  o_jal  = 1'b1;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS control sequencer
// Drives PC/IR/regfile/ALU/memory controls from state plus the decoded instruction class.
module mc_control
  import mc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_run,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_cen_n,
  output logic       o_mem_wen_n,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic [1:0] o_pc_src,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic       o_reg_write,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic       o_retire,
  output logic       o_trap
);

  state_t r_state;
  state_t w_next;

  logic w_rtype, w_jr, w_lw, w_sw, w_addi, w_beq, w_bne, w_j, w_jal, w_illegal;

  mc_decode u_decode (
    .i_opcode  (i_opcode),
    .i_funct   (i_funct),
    .o_rtype   (w_rtype),
    .o_jr      (w_jr),
    .o_lw      (w_lw),
    .o_sw      (w_sw),
    .o_addi    (w_addi),
    .o_beq     (w_beq),
    .o_bne     (w_bne),
    .o_j       (w_j),
    .o_jal     (w_jal),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_mem_cen_n  = 1'b1;
    o_mem_wen_n  = 1'b1;
    o_iord       = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = PC_SRC_ALU;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = ALU_B_RT;
    o_alu_op     = ALU_OP_ADD;
    o_reg_write  = 1'b0;
    o_reg_dst    = REG_DST_RT;
    o_mem_to_reg = WB_ALUOUT;
    o_retire     = 1'b0;
    o_trap       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_run) w_next = ST_FETCH;
      end

      ST_FETCH: begin
        o_mem_cen_n = 1'b0;
        o_alu_src_b = ALU_B_FOUR;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // ALU computes PC+4+(imm<<2) here so branches can use ALU-out in EXEC
        o_alu_src_b = ALU_B_IMM_SH2;
        if (w_j || w_jal) begin
          o_pc_write = 1'b1;
          o_pc_src   = PC_SRC_JUMP;
          o_retire   = 1'b1;
          w_next     = ST_FETCH;
          if (w_jal) begin
            o_reg_write  = 1'b1;
            o_reg_dst    = REG_DST_RA;
            o_mem_to_reg = WB_PC;
          end
        end else if (w_illegal) begin
          w_next = ST_TRAP;
        end else begin
          w_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (w_rtype) begin
          o_alu_src_a = 1'b1;
          o_alu_op    = ALU_OP_FUNCT;
          w_next      = ST_WB;
        end else if (w_jr) begin
          o_pc_write = 1'b1;
          o_pc_src   = PC_SRC_RS;
          o_retire   = 1'b1;
          w_next     = ST_FETCH;
        end else if (w_lw || w_sw || w_addi) begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = ALU_B_IMM;
          w_next      = w_addi ? ST_WB : ST_MEM;
        end else if (w_beq || w_bne) begin
          o_alu_src_a = 1'b1;
          o_alu_op    = ALU_OP_SUB;
          o_pc_src    = PC_SRC_ALUOUT;
          o_pc_write  = w_beq ? i_zero : ~i_zero;
          o_retire    = 1'b1;
          w_next      = ST_FETCH;
        end else begin
          // IR changed under us to a class that cannot reach EXEC
          w_next = ST_TRAP;
        end
      end

      ST_MEM: begin
        o_mem_cen_n = 1'b0;
        o_iord      = 1'b1;
        o_mem_wen_n = ~w_sw;
        if (i_mem_ready) begin
          if (w_sw) begin
            o_retire = 1'b1;
            w_next   = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end
      end

      ST_WB: begin
        o_reg_write  = 1'b1;
        o_retire     = 1'b1;
        o_reg_dst    = w_rtype ? REG_DST_RD : REG_DST_RT;
        o_mem_to_reg = w_lw ? WB_MDR : WB_ALUOUT;
        w_next       = ST_FETCH;
      end

      ST_TRAP: begin
        o_trap = 1'b1;
      end

      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - randomized scoreboard bench for mc_control
module tb_mc_control;

  localparam int C_R = 0, C_JR = 1, C_LW = 2, C_SW = 3, C_ADDI = 4;
  localparam int C_BEQ = 5, C_BNE = 6, C_J = 7, C_JAL = 8, C_ILL = 9;

  typedef struct packed {
    logic       cen_n;
    logic       wen_n;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       retire;
    logic       trap;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_cen_n, mem_wen_n, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       reg_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       retire, trap;

  int n_checks = 0;
  int n_errors = 0;
  int n_retire_seen = 0;
  int n_retire_exp = 0;

  ctl_t  exp_q[$];
  string tag_q[$];
  ctl_t  mon_e;
  string mon_t;

  mc_control dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_run        (run),
    .i_opcode     (opcode),
    .i_funct      (funct),
    .i_zero       (zero),
    .i_mem_ready  (mem_ready),
    .o_mem_cen_n  (mem_cen_n),
    .o_mem_wen_n  (mem_wen_n),
    .o_iord       (iord),
    .o_ir_write   (ir_write),
    .o_pc_write   (pc_write),
    .o_pc_src     (pc_src),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_alu_op     (alu_op),
    .o_reg_write  (reg_write),
    .o_reg_dst    (reg_dst),
    .o_mem_to_reg (mem_to_reg),
    .o_retire     (retire),
    .o_trap       (trap)
  );

  always #5 clk = ~clk;

  function automatic ctl_t sample();
    ctl_t c;
    c = '{mem_cen_n, mem_wen_n, iord, ir_write, pc_write, pc_src, alu_src_a,
          alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, retire, trap};
    return c;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference behaviour: what each phase of an instruction should drive
  function automatic ctl_t m_idle();
    ctl_t c = '0;
    c.cen_n = 1'b1;
    c.wen_n = 1'b1;
    return c;
  endfunction

  function automatic ctl_t m_trap();
    ctl_t c = m_idle();
    c.trap = 1'b1;
    return c;
  endfunction

  function automatic ctl_t m_fetch(input bit rdy);
    ctl_t c = m_idle();
    c.cen_n = 1'b0;
    c.src_b = 2'b01;
    c.ir_write = rdy;
    c.pc_write = rdy;
    return c;
  endfunction

  function automatic ctl_t m_decode(input int cls);
    ctl_t c = m_idle();
    c.src_b = 2'b11;
    if (cls == C_J || cls == C_JAL) begin
      c.pc_write = 1'b1;
      c.pc_src = 2'b10;
      c.retire = 1'b1;
    end
    if (cls == C_JAL) begin
      c.reg_write = 1'b1;
      c.reg_dst = 2'b10;
      c.mem_to_reg = 2'b10;
    end
    return c;
  endfunction

  function automatic ctl_t m_exec(input int cls, input bit z);
    ctl_t c = m_idle();
    case (cls)
      C_R: begin c.src_a = 1'b1; c.alu_op = 2'b10; end
      C_JR: begin c.pc_write = 1'b1; c.pc_src = 2'b11; c.retire = 1'b1; end
      C_LW, C_SW, C_ADDI: begin c.src_a = 1'b1; c.src_b = 2'b10; end
      default: begin
        c.src_a = 1'b1;
        c.alu_op = 2'b01;
        c.pc_src = 2'b01;
        c.retire = 1'b1;
        c.pc_write = (cls == C_BEQ) ? z : !z;
      end
    endcase
    return c;
  endfunction

  function automatic ctl_t m_mem(input int cls, input bit rdy);
    ctl_t c = m_idle();
    c.cen_n = 1'b0;
    c.iord = 1'b1;
    c.wen_n = (cls != C_SW);
    c.retire = (cls == C_SW) && rdy;
    return c;
  endfunction

  function automatic ctl_t m_wb(input int cls);
    ctl_t c = m_idle();
    c.reg_write = 1'b1;
    c.retire = 1'b1;
    c.reg_dst = (cls == C_R) ? 2'b01 : 2'b00;
    c.mem_to_reg = (cls == C_LW) ? 2'b01 : 2'b00;
    return c;
  endfunction

  function automatic logic [5:0] op_of(input int cls);
    case (cls)
      C_R, C_JR: return 6'b000000;
      C_LW:      return 6'b100011;
      C_SW:      return 6'b101011;
      C_ADDI:    return 6'b001000;
      C_BEQ:     return 6'b000100;
      C_BNE:     return 6'b000101;
      C_J:       return 6'b000010;
      C_JAL:     return 6'b000011;
      default: begin
        case ($urandom_range(0, 3))
          0:       return 6'b111111;
          1:       return 6'b000001;
          2:       return 6'b010000;
          default: return 6'b101010;
        endcase
      end
    endcase
  endfunction

  function automatic logic [5:0] fn_of(input int cls);
    logic [5:0] f;
    if (cls == C_JR) return 6'b001000;
    do f = 6'($urandom); while (cls == C_R && f == 6'b001000);
    return f;
  endfunction

  // One clock of stimulus: inputs land just after a rising edge, the
  // expected outputs for that cycle go to the scoreboard
  task automatic cyc(input string tag, input bit rdy, input logic [5:0] op,
                     input logic [5:0] fn, input bit z, input bit rn, input ctl_t e);
    mem_ready = rdy;
    opcode = op;
    funct = fn;
    zero = z;
    run = rn;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int cls, input int fw, input int mw, input bit z,
                           input logic [5:0] fn);
    logic [5:0] op = op_of(cls);
    for (int k = 0; k < fw; k++)
      cyc("fetch_wait", 1'b0, 6'($urandom), 6'($urandom), rb(), rb(), m_fetch(1'b0));
    cyc("fetch", 1'b1, 6'($urandom), 6'($urandom), rb(), rb(), m_fetch(1'b1));
    cyc("decode", rb(), op, fn, rb(), rb(), m_decode(cls));
    if (cls == C_ILL) begin
      for (int k = 0; k < 6; k++)
        cyc("trap_hold", rb(), 6'($urandom), 6'($urandom), rb(), rb(), m_trap());
      return;
    end
    n_retire_exp++;
    if (cls == C_J || cls == C_JAL) return;
    cyc("exec", rb(), op, fn, z, rb(), m_exec(cls, z));
    if (cls == C_JR || cls == C_BEQ || cls == C_BNE) return;
    if (cls == C_LW || cls == C_SW) begin
      for (int k = 0; k < mw; k++)
        cyc("mem_wait", 1'b0, op, fn, rb(), rb(), m_mem(cls, 1'b0));
      cyc("mem", 1'b1, op, fn, rb(), rb(), m_mem(cls, 1'b1));
      if (cls == C_SW) return;
    end
    cyc("wb", rb(), op, fn, rb(), rb(), m_wb(cls));
  endtask

  always @(negedge clk) begin
    if (retire === 1'b1) n_retire_seen++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      check(mon_t, 32'(sample()), 32'(mon_e));
    end
  end

  initial begin
    int cls;
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", 32'(sample()), 32'(m_idle()));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++)
      cyc("idle_norun", rb(), 6'($urandom), 6'($urandom), rb(), 1'b0, m_idle());
    cyc("idle_run", rb(), 6'($urandom), 6'($urandom), rb(), 1'b1, m_idle());

    run_instr(C_R, 0, 0, 1'b0, 6'b100000);
    run_instr(C_LW, 0, 3, 1'b0, fn_of(C_LW));
    run_instr(C_BEQ, 0, 0, 1'b1, fn_of(C_BEQ));
    run_instr(C_BNE, 0, 0, 1'b1, fn_of(C_BNE));
    run_instr(C_JAL, 1, 0, 1'b0, fn_of(C_JAL));
    run_instr(C_JR, 0, 0, 1'b0, fn_of(C_JR));
    run_instr(C_SW, 2, 2, 1'b0, fn_of(C_SW));

    for (int n = 0; n < 80; n++) begin
      cls = $urandom_range(0, 8);
      run_instr(cls, $urandom_range(0, 2), $urandom_range(0, 3), rb(), fn_of(cls));
    end

    // Reset in the middle of a store's memory wait
    cyc("fetch", 1'b1, 6'($urandom), 6'($urandom), rb(), rb(), m_fetch(1'b1));
    cyc("decode", 1'b1, op_of(C_SW), 6'($urandom), rb(), rb(), m_decode(C_SW));
    cyc("exec", 1'b1, op_of(C_SW), 6'($urandom), rb(), rb(), m_exec(C_SW, 1'b0));
    mem_ready = 1'b0;
    #2 check("sw_wait_strobes", 32'({mem_cen_n, mem_wen_n}), 32'(2'b00));
    rst_n = 1'b0;
    #1 check("sw_async_reset", 32'(sample()), 32'(m_idle()));
    @(posedge clk); #1;
    cyc("reset_hold", rb(), 6'($urandom), 6'($urandom), rb(), 1'b1, m_idle());
    rst_n = 1'b1;
    cyc("idle_after_rst", rb(), 6'($urandom), 6'($urandom), rb(), 1'b0, m_idle());
    cyc("idle_run", rb(), 6'($urandom), 6'($urandom), rb(), 1'b1, m_idle());

    for (int n = 0; n < 10; n++) begin
      cls = $urandom_range(0, 8);
      run_instr(cls, $urandom_range(0, 1), $urandom_range(0, 2), rb(), fn_of(cls));
    end
    run_instr(C_ILL, 0, 0, 1'b0, fn_of(C_ILL));

    rst_n = 1'b0;
    #1 check("trap_cleared", 32'(sample()), 32'(m_idle()));
    @(posedge clk); #1;
    cyc("reset_hold", rb(), 6'($urandom), 6'($urandom), rb(), 1'b1, m_idle());
    rst_n = 1'b1;
    cyc("idle_after_trap", rb(), 6'($urandom), 6'($urandom), rb(), 1'b0, m_idle());
    cyc("idle_after_trap", rb(), 6'($urandom), 6'($urandom), rb(), 1'b0, m_idle());
    cyc("idle_run", rb(), 6'($urandom), 6'($urandom), rb(), 1'b1, m_idle());
    run_instr(C_J, 0, 0, 1'b0, fn_of(C_J));
    run_instr(C_ADDI, 1, 0, 1'b0, fn_of(C_ADDI));

    @(negedge clk); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("retire_count", 32'(n_retire_seen), 32'(n_retire_exp));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
